procyon_lsu_lq_entry: RTL and testbench

Single load-queue entry tracking one speculative load from launch into the LSU pipeline until ROB retirement. It is a sibling consumer of the store-queue retire broadcast: every store launched from the SQ is compared against this entry to detect mis-speculated loads. It also handles MHQ retry/replay the same way SQ entries do. N copies are instantiated by the LQ top, which allocates them and arbitrates among replayable entries.

---
 rtl/procyon_lsu_lq_entry.sv | 168 ++++++++++++++++
 tb/tb_procyon_lsu_lq_entry.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/procyon_lsu_lq_entry.sv
// Load queue entry: tracks one speculative load from launch until ROB retire.
// It snoops retiring stores for overlap and follows the MHQ retry/replay flow.
`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 5
`endif
`ifndef PCYN_OP_LB
`define PCYN_OP_LB  5'h08
`define PCYN_OP_LH  5'h09
`define PCYN_OP_LW  5'h0A
`define PCYN_OP_LBU 5'h0B
`define PCYN_OP_LHU 5'h0C
`define PCYN_OP_SB  5'h0D
`define PCYN_OP_SH  5'h0E
`define PCYN_OP_SW  5'h0F
`endif

module procyon_lsu_lq_entry #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  output logic                          o_empty,
  output logic                          o_replayable,
  input  logic                          i_alloc_en,
  input  logic [`PCYN_OP_WIDTH-1:0]     i_alloc_op,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_alloc_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_alloc_addr,
  input  logic                          i_replay_en,
  output logic [`PCYN_OP_WIDTH-1:0]     o_replay_op,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_replay_tag,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_replay_addr,
  input  logic                          i_update_en,
  input  logic                          i_update_retry,
  input  logic                          i_update_replay,
  input  logic                          i_update_mhq_retry,
  input  logic                          i_update_mhq_replay,
  input  logic                          i_mhq_fill_en,
  input  logic                          i_sq_retire_en,
  input  logic [`PCYN_OP_WIDTH-1:0]     i_sq_retire_op,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_sq_retire_addr,
  input  logic                          i_rob_retire_en,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rob_retire_tag,
  output logic                          o_rob_retire_ack,
  output logic                          o_rob_retire_misspeculated
);

  localparam int MASK_W = OPTN_DATA_WIDTH / 8;

  localparam logic [2:0] INVALID       = 3'b000;
  localparam logic [2:0] LAUNCHED      = 3'b001;
  localparam logic [2:0] MHQ_FILL_WAIT = 3'b010;
  localparam logic [2:0] REPLAYABLE    = 3'b011;
  localparam logic [2:0] COMPLETE      = 3'b100;

  logic [2:0]                    state_r;
  logic [2:0]                    state_next;
  logic                          misspec_r;
  logic [`PCYN_OP_WIDTH-1:0]     op_r;
  logic [OPTN_ROB_IDX_WIDTH-1:0] tag_r;
  logic [OPTN_ADDR_WIDTH-1:0]    addr_r;

  logic                          alloc;
  logic [2:0]                    update_sel;
  logic [MASK_W-1:0]             ld_mask;
  logic [MASK_W-1:0]             st_mask;
  logic                          overlap;
  logic                          misspec_hit;
  logic                          ack;

  function automatic logic [MASK_W-1:0] gen_mask(
    input logic [`PCYN_OP_WIDTH-1:0] op,
    input logic [1:0]                a
  );
    logic [MASK_W-1:0] m;
    case (op)
      `PCYN_OP_LB, `PCYN_OP_LBU, `PCYN_OP_SB:
        m = MASK_W'(1) << a;
      `PCYN_OP_LH, `PCYN_OP_LHU, `PCYN_OP_SH:
        m = MASK_W'(3) << a;
      default:
        m = '1;
    endcase
    return m;
  endfunction

  assign alloc      = i_alloc_en & (state_r == INVALID);
  assign update_sel = {i_update_retry,
                       i_update_replay | i_update_mhq_replay,
                       i_update_mhq_retry};

  assign ld_mask = gen_mask(op_r, addr_r[1:0]);
  assign st_mask = gen_mask(i_sq_retire_op, i_sq_retire_addr[1:0]);
  assign overlap = (addr_r[OPTN_ADDR_WIDTH-1:2]
                    == i_sq_retire_addr[OPTN_ADDR_WIDTH-1:2])
                 & (|(ld_mask & st_mask));

  // Entries waiting on the MHQ will re-read the cache, so only these can hit
  assign misspec_hit = i_sq_retire_en & overlap
                     & ((state_r == LAUNCHED) | (state_r == COMPLETE));

  assign ack = i_rob_retire_en
             & (tag_r == i_rob_retire_tag)
             & (state_r == COMPLETE);

  always_comb begin
    state_next = state_r;
    case (state_r)
      INVALID:
        if (i_alloc_en) state_next = LAUNCHED;
      LAUNCHED:
        if (i_flush) state_next = INVALID;
        else if (i_update_en) begin
          case (update_sel)
            3'b101:
              state_next = i_mhq_fill_en ? REPLAYABLE
                                         : MHQ_FILL_WAIT;
            3'b110, 3'b111:
              state_next = REPLAYABLE;
            default:
              state_next = COMPLETE;
          endcase
        end
      MHQ_FILL_WAIT:
        if (i_flush) state_next = INVALID;
        else if (i_mhq_fill_en) state_next = REPLAYABLE;
      REPLAYABLE:
        if (i_flush) state_next = INVALID;
        else if (i_replay_en) state_next = LAUNCHED;
      COMPLETE:
        if (i_flush) state_next = INVALID;
        else if (ack) state_next = INVALID;
      default:
        state_next = INVALID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r   <= INVALID;
      misspec_r <= 1'b0;
    end else begin
      state_r <= state_next;
      if (alloc) misspec_r <= 1'b0;
      else if (misspec_hit) misspec_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      op_r   <= i_alloc_op;
      tag_r  <= i_alloc_tag;
      addr_r <= i_alloc_addr;
    end
  end

  assign o_empty       = (state_r == INVALID);
  assign o_replayable  = (state_r == REPLAYABLE);
  assign o_replay_op   = op_r;
  assign o_replay_tag  = tag_r;
  assign o_replay_addr = addr_r;

  assign o_rob_retire_ack           = ack;
  assign o_rob_retire_misspeculated = ack & (misspec_r | misspec_hit);

endmodule

// File: tb/tb_procyon_lsu_lq_entry.sv
// Directed bench for procyon_lsu_lq_entry.
// Expected outputs are queued at drive time and popped when sampled.
`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 5
`endif

module tb_procyon_lsu_lq_entry;

  localparam logic [4:0] LB  = 5'h08;
  localparam logic [4:0] LH  = 5'h09;
  localparam logic [4:0] LW  = 5'h0A;
  localparam logic [4:0] LBU = 5'h0B;
  localparam logic [4:0] SB  = 5'h0D;
  localparam logic [4:0] SW  = 5'h0F;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_flush;
  logic        o_empty;
  logic        o_replayable;
  logic        i_alloc_en;
  logic [4:0]  i_alloc_op;
  logic [4:0]  i_alloc_tag;
  logic [31:0] i_alloc_addr;
  logic        i_replay_en;
  logic [4:0]  o_replay_op;
  logic [4:0]  o_replay_tag;
  logic [31:0] o_replay_addr;
  logic        i_update_en;
  logic        i_update_retry;
  logic        i_update_replay;
  logic        i_update_mhq_retry;
  logic        i_update_mhq_replay;
  logic        i_mhq_fill_en;
  logic        i_sq_retire_en;
  logic [4:0]  i_sq_retire_op;
  logic [31:0] i_sq_retire_addr;
  logic        i_rob_retire_en;
  logic [4:0]  i_rob_retire_tag;
  logic        o_rob_retire_ack;
  logic        o_rob_retire_misspeculated;

  procyon_lsu_lq_entry dut (
    .clk                        (clk),
    .n_rst                      (n_rst),
    .i_flush                    (i_flush),
    .o_empty                    (o_empty),
    .o_replayable               (o_replayable),
    .i_alloc_en                 (i_alloc_en),
    .i_alloc_op                 (i_alloc_op),
    .i_alloc_tag                (i_alloc_tag),
    .i_alloc_addr               (i_alloc_addr),
    .i_replay_en                (i_replay_en),
    .o_replay_op                (o_replay_op),
    .o_replay_tag               (o_replay_tag),
    .o_replay_addr              (o_replay_addr),
    .i_update_en                (i_update_en),
    .i_update_retry             (i_update_retry),
    .i_update_replay            (i_update_replay),
    .i_update_mhq_retry         (i_update_mhq_retry),
    .i_update_mhq_replay        (i_update_mhq_replay),
    .i_mhq_fill_en              (i_mhq_fill_en),
    .i_sq_retire_en             (i_sq_retire_en),
    .i_sq_retire_op             (i_sq_retire_op),
    .i_sq_retire_addr           (i_sq_retire_addr),
    .i_rob_retire_en            (i_rob_retire_en),
    .i_rob_retire_tag           (i_rob_retire_tag),
    .o_rob_retire_ack           (o_rob_retire_ack),
    .o_rob_retire_misspeculated (o_rob_retire_misspeculated)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          fld;
    logic [63:0] v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic clear();
    i_flush             = 1'b0;
    i_alloc_en          = 1'b0;
    i_replay_en         = 1'b0;
    i_update_en         = 1'b0;
    i_update_retry      = 1'b0;
    i_update_replay     = 1'b0;
    i_update_mhq_retry  = 1'b0;
    i_update_mhq_replay = 1'b0;
    i_mhq_fill_en       = 1'b0;
    i_sq_retire_en      = 1'b0;
    i_rob_retire_en     = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clear();
  endtask

  task automatic want(string n, bit e, bit r, bit a, bit m);
    exp_t x;
    x.name = n;
    x.fld  = 1'b0;
    x.v    = {60'd0, e, r, a, m};
    q.push_back(x);
  endtask

  task automatic want_fld(string n, logic [4:0] op,
                          logic [4:0] tag, logic [31:0] addr);
    exp_t x;
    x.name = n;
    x.fld  = 1'b1;
    x.v    = {22'd0, op, tag, addr};
    q.push_back(x);
  endtask

  task automatic observe();
    exp_t        x;
    logic [63:0] o;
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      if (x.fld)
        o = {22'd0, o_replay_op, o_replay_tag, o_replay_addr};
      else
        o = {60'd0, o_empty, o_replayable,
             o_rob_retire_ack, o_rob_retire_misspeculated};
      n_vec++;
      assert (o === x.v) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", x.name, o, x.v);
      end
    end
  endtask

  task automatic alloc(logic [4:0] op, logic [4:0] tag, logic [31:0] a);
    i_alloc_en   = 1'b1;
    i_alloc_op   = op;
    i_alloc_tag  = tag;
    i_alloc_addr = a;
  endtask

  task automatic upd(bit rt, bit rp, bit mrt, bit mrp);
    i_update_en         = 1'b1;
    i_update_retry      = rt;
    i_update_replay     = rp;
    i_update_mhq_retry  = mrt;
    i_update_mhq_replay = mrp;
  endtask

  task automatic store(logic [4:0] op, logic [31:0] a);
    i_sq_retire_en   = 1'b1;
    i_sq_retire_op   = op;
    i_sq_retire_addr = a;
  endtask

  task automatic retire(logic [4:0] tag);
    i_rob_retire_en  = 1'b1;
    i_rob_retire_tag = tag;
  endtask

  initial begin
    clear();
    n_rst            = 1'b0;
    i_alloc_op       = '0;
    i_alloc_tag      = '0;
    i_alloc_addr     = '0;
    i_sq_retire_op   = '0;
    i_sq_retire_addr = '0;
    i_rob_retire_tag = '0;
    cyc();
    cyc();
    want("reset", 1, 0, 0, 0);
    observe();
    n_rst = 1'b1;
    cyc();

    // LW 0x100 completes cleanly and retires
    alloc(LW, 5'd3, 32'h100);
    cyc();
    want("lw_launched", 0, 0, 0, 0);
    observe();
    upd(0, 0, 0, 0);
    cyc();
    retire(5'd4);
    want("lw_wrong_tag", 0, 0, 0, 0);
    observe();
    cyc();
    retire(5'd3);
    want("lw_retire", 0, 0, 1, 0);
    observe();
    cyc();
    want("lw_empty", 1, 0, 0, 0);
    observe();

    // LH 0x102 vs SB 0x103 overlaps
    alloc(LH, 5'd5, 32'h102);
    cyc();
    store(SB, 32'h103);
    cyc();
    upd(0, 0, 0, 0);
    cyc();
    retire(5'd5);
    want("lh_sb_hit", 0, 0, 1, 1);
    observe();
    cyc();

    // LH 0x102 vs SB 0x101 misses on mask; alloc clears sticky flag
    alloc(LH, 5'd6, 32'h102);
    cyc();
    store(SB, 32'h101);
    cyc();
    upd(0, 0, 0, 0);
    cyc();
    retire(5'd6);
    want("lh_sb_miss", 0, 0, 1, 0);
    observe();
    cyc();

    // LB 0x200 through MHQ wait, fill, replay
    alloc(LB, 5'd7, 32'h200);
    cyc();
    upd(1, 0, 1, 0);
    cyc();
    want("mhq_wait", 0, 0, 0, 0);
    observe();
    store(SW, 32'h200);
    cyc();
    i_mhq_fill_en = 1'b1;
    cyc();
    want("fill_replayable", 0, 1, 0, 0);
    want_fld("replay_fields", LB, 5'd7, 32'h200);
    observe();
    i_replay_en = 1'b1;
    cyc();
    want("relaunched", 0, 0, 0, 0);
    want_fld("relaunch_addr", LB, 5'd7, 32'h200);
    observe();
    upd(0, 0, 0, 0);
    cyc();
    retire(5'd7);
    want("lb_retire_clean", 0, 0, 1, 0);
    observe();
    cyc();

    // update 101 with coincident fill goes straight to REPLAYABLE
    alloc(LBU, 5'd9, 32'h300);
    cyc();
    upd(1, 0, 1, 0);
    i_mhq_fill_en = 1'b1;
    cyc();
    want("fill_coincident", 0, 1, 0, 0);
    observe();
    i_replay_en = 1'b1;
    cyc();
    upd(1, 1, 0, 0);
    cyc();
    want("upd_110_replay", 0, 1, 0, 0);
    observe();
    i_flush = 1'b1;
    cyc();
    want("flush_replayable", 1, 0, 0, 0);
    observe();

    // same-cycle store and ROB retire on a complete entry
    alloc(LW, 5'd11, 32'h400);
    cyc();
    upd(0, 0, 0, 0);
    cyc();
    store(SW, 32'h400);
    retire(5'd11);
    want("same_cycle_hit", 0, 0, 1, 1);
    observe();
    cyc();
    want("same_cycle_empty", 1, 0, 0, 0);
    observe();

    // flush in LAUNCHED beats update
    alloc(LW, 5'd12, 32'h500);
    cyc();
    upd(0, 0, 0, 0);
    i_flush = 1'b1;
    cyc();
    want("flush_launched", 1, 0, 0, 0);
    observe();

    // flush from MHQ_FILL_WAIT
    alloc(LW, 5'd13, 32'h500);
    cyc();
    upd(1, 0, 1, 0);
    cyc();
    i_flush = 1'b1;
    cyc();
    want("flush_mhq_wait", 1, 0, 0, 0);
    observe();

    // flush from COMPLETE; stale tag no longer acks
    alloc(LW, 5'd14, 32'h500);
    cyc();
    upd(0, 0, 0, 0);
    cyc();
    i_flush = 1'b1;
    cyc();
    retire(5'd14);
    want("flush_complete", 1, 0, 0, 0);
    observe();
    cyc();

    // alloc coincident with store does not mark misspec
    alloc(LW, 5'd15, 32'h600);
    store(SW, 32'h600);
    cyc();
    upd(0, 0, 0, 0);
    cyc();
    retire(5'd15);
    want("alloc_store_same", 0, 0, 1, 0);
    observe();
    cyc();

    // reset mid-LAUNCHED after a hit
    alloc(LW, 5'd2, 32'h700);
    cyc();
    store(SW, 32'h700);
    cyc();
    n_rst = 1'b0;
    cyc();
    want("reset_mid", 1, 0, 0, 0);
    observe();
    n_rst = 1'b1;
    cyc();
    want("reset_hold", 1, 0, 0, 0);
    observe();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
